// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: read-side scheduler for the async FIFO read domain.
// Shares the FIFO read port among NUM_REQ consumers with round-robin
// arbitration and bounded bursts. It never strobes an empty FIFO, and it
// tags every returned word with the consumer that issued the read.
// Optional build macro: FIFO_SCHED_PRIO_EN makes req[0] a high-priority
// consumer. Other owners' bursts are cut to one word while req[0] is high,
// and round-robin then runs among req[NUM_REQ-1:1] only.
module fifo_rd_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                clk_r,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                fifo_rd_en,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [DATA_W-1:0]   data_o,
  output logic [NUM_REQ-1:0]  valid_o,
  output logic                busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

`ifdef FIFO_SCHED_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Registers
  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [OW-1:0]       r_owner;
  logic [BW-1:0]       r_beat_cnt;
  logic [OW-1:0]       r_last_owner;
  logic                r_busy;
  logic                r_p1_vld;      // a read was strobed last cycle
  logic [OW-1:0]       r_p1_owner;    // owner tag travelling with that read
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REQ-1:0]  r_valid;

  // Combinational
  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_grant_nxt;
  logic [OW-1:0]       w_owner_nxt;
  logic [BW-1:0]       w_beat_nxt;
  logic [OW-1:0]       w_last_nxt;
  logic [OW:0]         w_arb;         // {found, picked index}
  logic                w_rd_en;
  logic [BW-1:0]       w_beat_inc;
  logic                w_cut;
  logic                w_exit;

  // Index base+step wrapped into 0..NUM_REQ-1. Since step <= NUM_REQ and
  // base < NUM_REQ, a single subtraction is enough.
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    return s[OW-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scans from last+1 upward and returns the first requester. Under priority
  // mode, index 0 is skipped in the scan and instead overrides the result.
  function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                          input logic [OW-1:0]      last);
    logic          found;
    logic          hit;
    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand  = wrap_idx(last, i);
      hit   = ~found & rq[cand] & ~(PRIO_EN & (cand == {OW{1'b0}}));
      pick  = hit ? cand : pick;
      found = found | hit;
    end
    pick  = (PRIO_EN && rq[0]) ? {OW{1'b0}} : pick;
    found = found | (PRIO_EN & rq[0]);
    return {found, pick};
  endfunction

  assign w_arb      = rr_pick(req, r_last_owner);
  assign w_rd_en    = (r_state == ST_BURST) & req[r_owner] & ~fifo_empty &
                      (r_beat_cnt < BW'(BURST_MAX));
  assign w_beat_inc = r_beat_cnt + BW'(w_rd_en);
  assign w_cut      = PRIO_EN & req[0] & (r_owner != {OW{1'b0}}) & w_rd_en;
  assign w_exit     = (w_beat_inc == BW'(BURST_MAX)) | ~req[r_owner] | fifo_empty | w_cut;

  assign fifo_rd_en = w_rd_en;
  assign grant      = r_grant;
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign busy       = r_busy;

  // Next-state logic: arbitrate in IDLE, count beats and decide exit in BURST
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat_cnt;
    w_last_nxt  = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_arb[OW] && !fifo_empty) begin
          w_state_nxt = ST_BURST;
          w_owner_nxt = w_arb[OW-1:0];
          w_grant_nxt = onehot(w_arb[OW-1:0]);
          w_beat_nxt  = {BW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        w_beat_nxt = w_beat_inc;
        if (w_exit) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
          w_grant_nxt = {NUM_REQ{1'b0}};
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NUM_REQ{1'b0}};
        w_beat_nxt  = {BW{1'b0}};
      end
    endcase
  end

  // Scheduler state register
  always_ff @(posedge clk_r) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= {NUM_REQ{1'b0}};
      r_owner      <= {OW{1'b0}};
      r_beat_cnt   <= {BW{1'b0}};
      r_last_owner <= OW'(NUM_REQ - 1);
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_last_owner <= w_last_nxt;
      r_busy       <= (w_state_nxt == ST_BURST);
    end
  end

  // Return path: the owner tag follows the strobe, so words reach the right
  // consumer even after the grant has moved on
  always_ff @(posedge clk_r) begin
    if (reset) begin
      r_p1_vld   <= 1'b0;
      r_p1_owner <= {OW{1'b0}};
      r_data     <= {DATA_W{1'b0}};
      r_valid    <= {NUM_REQ{1'b0}};
    end else begin
      r_p1_vld   <= w_rd_en;
      r_p1_owner <= r_owner;
      if (r_p1_vld) begin
        r_data  <= fifo_data;
        r_valid <= onehot(r_p1_owner);
      end else begin
        r_data  <= r_data;
        r_valid <= {NUM_REQ{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Testbench for fifo_rd_sched: a FIFO model feeds the DUT, and a scoreboard
// holds each expected word/owner with the edge at which it must appear.
module tb_fifo_rd_sched;

  logic       clk_r;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] data_o;
  logic [3:0] valid_o;
  logic       busy;

  typedef struct packed {
    int         due;
    logic [3:0] own;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] fq[$];
  int         n_checks;
  int         n_errors;
  int         edges;
  int         exp_own;
  int         rd_cnt;
  logic       rd_s;
  logic [7:0] fill_val;

  fifo_rd_sched #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk_r      (clk_r),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .req        (req),
    .grant      (grant),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .busy       (busy)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(fill_val);
      fill_val = fill_val + 8'd1;
    end
  endtask

  // One clock: sample the strobe mid-cycle, then update the FIFO model and
  // score the return path just after the edge.
  task automatic cyc();
    sb_t        e;
    logic [3:0] oh;
    fifo_empty = (fq.size() == 0);
    @(negedge clk_r);
    rd_s = fifo_rd_en;
    check_eq("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    if (rd_s) rd_cnt++;
    if (rd_s && !reset && fq.size() > 0) begin
      oh = 4'b0001 << exp_own;
      sb_q.push_back('{due: edges + 2, own: oh, data: fq[0]});
    end
    @(posedge clk_r);
    #1;
    edges++;
    if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
    if (sb_q.size() > 0 && sb_q[0].due == edges) begin
      e = sb_q.pop_front();
      check_eq("valid_o", 32'(valid_o), 32'(e.own));
      check_eq("data_o", 32'(data_o), 32'(e.data));
    end else begin
      check_eq("valid_idle", 32'(valid_o), 32'd0);
    end
  endtask

  // Arbitration cycle, then the burst until grant drops.
  task automatic burst(input int own, input int n_reads);
    logic [3:0] oh;
    oh      = 4'b0001 << own;
    exp_own = own;
    cyc();
    check_eq("grant", 32'(grant), 32'(oh));
    check_eq("busy", 32'(busy), 32'd1);
    rd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (grant == 4'b0000) break;
    end
    check_eq("burst_reads", 32'(rd_cnt), 32'(n_reads));
    check_eq("grant_idle", 32'(grant), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    repeat (5) cyc();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    edges     = 0;
    exp_own   = 0;
    rd_cnt    = 0;
    rd_s      = 1'b0;
    fill_val  = 8'h60;
    reset     = 1'b1;
    req       = 4'b0000;
    fifo_empty = 1'b1;
    fifo_data = 8'h00;

    // Reset state
    cyc();
    cyc();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // Single requester: a four-word burst, then 0x55 in a new burst
    fq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset = 1'b0;
    req   = 4'b0001;
    burst(0, 4);
    burst(0, 1);
    req = 4'b0000;
    drain();

    // Two requesters alternate with full bursts
    fill(16);
    req = 4'b1010;
    burst(1, 4);
    burst(3, 4);
    burst(1, 4);
    req = 4'b0000;
    drain();

    // FIFO runs empty after two reads of owner 2
    fq.delete();
    fill(2);
    req = 4'b0100;
    burst(2, 2);
    cyc();
    check_eq("empty_no_grant", 32'(grant), 32'd0);
    req = 4'b0000;
    drain();

    // Owner 1 drops req after its first read
    fill(8);
    req     = 4'b0010;
    exp_own = 1;
    cyc();
    check_eq("drop_grant", 32'(grant), 32'd2);
    rd_cnt = 0;
    cyc();
    req = 4'b0000;
    cyc();
    check_eq("drop_reads", 32'(rd_cnt), 32'd1);
    check_eq("drop_idle", 32'(grant), 32'd0);
    req = 4'b0111;
    burst(2, 4);
    req = 4'b0000;
    drain();

    // Reset one cycle after a read: in-flight word discarded
    fill(8);
    req     = 4'b1000;
    exp_own = 3;
    cyc();
    check_eq("pre_rst_grant", 32'(grant), 32'd8);
    cyc();
    reset = 1'b1;
    sb_q.delete();
    cyc();
    check_eq("mid_rst_grant", 32'(grant), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_data", 32'(data_o), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    reset   = 1'b0;
    req     = 4'b1001;
    exp_own = 0;
    cyc();
    check_eq("post_rst_grant", 32'(grant), 32'd1);
    req = 4'b0000;
    cyc();
    check_eq("post_rst_idle", 32'(grant), 32'd0);
    drain();

    // Owner 2 bursting while req[0] rises
    fill(8);
    req     = 4'b0100;
    exp_own = 2;
    cyc();
    check_eq("prio_grant2", 32'(grant), 32'd4);
    req    = 4'b0101;
    rd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (grant == 4'b0000) break;
    end
`ifdef FIFO_SCHED_PRIO_EN
    check_eq("prio_cut_reads", 32'(rd_cnt), 32'd1);
`else
    check_eq("rr_full_reads", 32'(rd_cnt), 32'd4);
`endif
    exp_own = 0;
    cyc();
    check_eq("prio_next_grant", 32'(grant), 32'd1);
    req = 4'b0000;
    cyc();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
